hazard_ctrl: RTL

Pipeline sequencer for the fetch/decode/execute front end: generates the PC write enable, the fetch-decode register write enable (`instWrite`), the fetch-decode flush and the decode-execute bubble. It resolves load-use hazards, taken-branch redirects and multi-cycle instruction-memory fetches with a small state machine. It sits beside the FD register and drives its control inputs directly.

---
 rtl/hazard_ctrl_pkg.sv | 22 ++
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl_load_use.sv | 16 +
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control types: FSM encodings, the NOP word and RV32 opcodes.
// Latency: n/a (types and constants only); backpressure: n/a.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH     = 2'd1,
        IMEM_WAIT = 2'd2,
        DISCARD   = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] R_TYPE             = 7'b0110011;
    localparam logic [6:0] I_TYPE_CALCUTATION = 7'b0010011;
    localparam logic [6:0] I_TYPE_JALR        = 7'b1100111;
    localparam logic [6:0] LOAD               = 7'b0000011;
    localparam logic [6:0] STORE              = 7'b0100011;
    localparam logic [6:0] B_TYPE             = 7'b1100011;
    localparam logic [6:0] J_TYPE             = 7'b1101111;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Control bundle between the FD/DE/PC datapath (master) and hazard_ctrl (slave).
// HAZARD_CTRL_PERF_EN adds the stall/flush counter outputs.
interface hazard_ctrl_if;

    logic       imemReady;
    logic [4:0] fdRs1;
    logic [4:0] fdRs2;
    logic       fdUsesRs2;
    logic [4:0] deRd;
    logic       deIsLoad;
    logic       exBranchTaken;

    logic       pcWrite;
    logic       instWrite;
    logic       fdFlush;
    logic       deBubble;
    logic [1:0] state;
`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stallCount;
    logic [31:0] flushCount;
`endif

    modport master (
`ifdef HAZARD_CTRL_PERF_EN
        input  stallCount, flushCount,
`endif
        output imemReady, fdRs1, fdRs2, fdUsesRs2, deRd, deIsLoad, exBranchTaken,
        input  pcWrite, instWrite, fdFlush, deBubble, state
    );

    modport slave (
`ifdef HAZARD_CTRL_PERF_EN
        output stallCount, flushCount,
`endif
        input  imemReady, fdRs1, fdRs2, fdUsesRs2, deRd, deIsLoad, exBranchTaken,
        output pcWrite, instWrite, fdFlush, deBubble, state
    );

endinterface

// File: rtl/hazard_ctrl_load_use.sv
// Load-use hazard compare between the DE load destination and the FD sources.
// Latency: combinational; backpressure: none.
module load_use_detect (
    input  logic       i_de_is_load,
    input  logic [4:0] i_de_rd,
    input  logic [4:0] i_fd_rs1,
    input  logic [4:0] i_fd_rs2,
    input  logic       i_fd_uses_rs2,
    output logic       o_hazard
);

    // x0 is hardwired, so a load targeting it can never create a dependency.
    assign o_hazard = i_de_is_load && (i_de_rd != 5'd0) &&
                      ((i_de_rd == i_fd_rs1) || (i_fd_uses_rs2 && (i_de_rd == i_fd_rs2)));

endmodule

// File: rtl/hazard_ctrl.sv
// PC/FD/DE sequencer for load-use stalls, branch flushes and slow fetches; outputs are
// combinational from state/cnt and inputs. HAZARD_CTRL_PERF_EN adds stall/flush counters.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic         CLK,
    input  logic         RST,
    hazard_ctrl_if.slave hc
);

    localparam logic [1:0] RELOAD    = 2'(FLUSH_CYCLES - 1);
    localparam state_t     AFTER_BR  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_t     r_state, w_next_state;
    logic [1:0] r_cnt, w_next_cnt;
    logic       w_load_use;
    logic       w_branch;
    logic       w_pc_write, w_inst_write, w_fd_flush, w_de_bubble;

    assign w_branch = hc.exBranchTaken;

    load_use_detect u_lud (
        .i_de_is_load (hc.deIsLoad),
        .i_de_rd      (hc.deRd),
        .i_fd_rs1     (hc.fdRs1),
        .i_fd_rs2     (hc.fdRs2),
        .i_fd_uses_rs2(hc.fdUsesRs2),
        .o_hazard     (w_load_use)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            RUN: begin
                if (w_branch) begin
                    w_next_state = AFTER_BR;
                    w_next_cnt   = RELOAD;
                end else if (!w_load_use && !hc.imemReady) begin
                    w_next_state = IMEM_WAIT;
                end
            end
            FLUSH: begin
                if (w_branch) begin
                    w_next_cnt = RELOAD;
                end else if (r_cnt <= 2'd1) begin
                    w_next_state = RUN;
                    w_next_cnt   = 2'd0;
                end else begin
                    w_next_cnt = r_cnt - 2'd1;
                end
            end
            IMEM_WAIT: begin
                // A redirect with a fetch still in flight must drop that stale word.
                if (w_branch) begin
                    w_next_state = hc.imemReady ? AFTER_BR : DISCARD;
                    w_next_cnt   = hc.imemReady ? RELOAD : r_cnt;
                end else if (!w_load_use && hc.imemReady) begin
                    w_next_state = RUN;
                end
            end
            DISCARD: begin
                if (!w_branch && hc.imemReady) begin
                    w_next_state = AFTER_BR;
                    w_next_cnt   = RELOAD;
                end
            end
            default: begin
                w_next_state = RUN;
                w_next_cnt   = 2'd0;
            end
        endcase
    end

    always_comb begin
        w_pc_write   = 1'b1;
        w_inst_write = 1'b1;
        w_fd_flush   = 1'b0;
        w_de_bubble  = 1'b0;
        if (RST) begin
            w_pc_write  = 1'b0;
            w_fd_flush  = 1'b1;
            w_de_bubble = 1'b1;
        end else if (w_branch) begin
            w_fd_flush  = 1'b1;
            w_de_bubble = 1'b1;
        end else begin
            case (r_state)
                RUN, IMEM_WAIT: begin
                    if (w_load_use) begin
                        w_pc_write   = 1'b0;
                        w_inst_write = 1'b0;
                        w_de_bubble  = 1'b1;
                    end else if (!hc.imemReady) begin
                        w_pc_write = 1'b0;
                        w_fd_flush = 1'b1;
                    end
                end
                FLUSH: begin
                    w_pc_write = hc.imemReady;
                    w_fd_flush = 1'b1;
                end
                default: begin
                    w_pc_write = 1'b0;
                    w_fd_flush = 1'b1;
                end
            endcase
        end
    end

    assign hc.pcWrite   = w_pc_write;
    assign hc.instWrite = w_inst_write;
    assign hc.fdFlush   = w_fd_flush;
    assign hc.deBubble  = w_de_bubble;
    assign hc.state     = r_state;

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] r_stall_count, r_flush_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            if (!w_pc_write) r_stall_count <= r_stall_count + 32'd1;
            if (w_fd_flush)  r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign hc.stallCount = r_stall_count;
    assign hc.flushCount = r_flush_count;
`endif

endmodule
